// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared state encoding and latency constants for the HI/LO sequencer
package hilo_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    START   = 2'b01,
    WAIT    = 2'b10,
    CAPTURE = 2'b11
  } hilo_state_t;

  localparam int MULT_CYCLES_DEFAULT = 33;
  localparam int CNT_W_DEFAULT       = $clog2(MULT_CYCLES_DEFAULT + 1);

endpackage

// File: rtl/hilo_wait_counter.sv
// rtl/hilo_wait_counter.sv - loadable down-counter with a terminal-count (==1) flag
module hilo_wait_counter
  import hilo_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEFAULT,
  parameter int LOAD_VAL = MULT_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic tc
);

  localparam logic [CNT_W-1:0] LOAD_V = CNT_W'(LOAD_VAL);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  logic [CNT_W-1:0] count;

  // Decrement only while nonzero so the count can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_V;
    end else if (dec && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign tc = (count == ONE);

endmodule

// File: rtl/hilo_sequencer.sv
// rtl/hilo_sequencer.sv - sequences the Booth multiplier and owns the architectural HI/LO registers
module hilo_sequencer
  import hilo_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mult_req,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              mthi_we,
  input  logic              mtlo_we,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mult_hi,
  input  logic [DATA_W-1:0] mult_lo,
  output logic              mult_start,
  output logic [DATA_W-1:0] mult_a,
  output logic [DATA_W-1:0] mult_b,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              busy,
  output logic              done,
  output logic              hazard
);

  localparam int CNT_W = $clog2(MULT_CYCLES + 1);

  hilo_state_t state_q;
  hilo_state_t state_d;
  logic        cnt_load;
  logic        cnt_dec;
  logic        cnt_tc;
  logic        idle;

  hilo_wait_counter #(
    .CNT_W    (CNT_W),
    .LOAD_VAL (MULT_CYCLES)
  ) u_wait_counter (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .dec   (cnt_dec),
    .tc    (cnt_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mult_req) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (cnt_tc) state_d = CAPTURE;
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // mult_start decodes straight from state so a reset drops it without waiting for an edge.
  always_comb begin
    idle       = (state_q == IDLE);
    busy       = !idle;
    mult_start = (state_q == START);
    cnt_load   = (state_q == START);
    cnt_dec    = (state_q == WAIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mult_a <= '0;
      mult_b <= '0;
    end else if (idle && mult_req) begin
      mult_a <= rs_val;
      mult_b <= rt_val;
    end
  end

  // Writes from the control unit land only in IDLE; CAPTURE is the only other writer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_out <= '0;
      lo_out <= '0;
    end else if (state_q == CAPTURE) begin
      hi_out <= mult_hi;
      lo_out <= mult_lo;
    end else if (idle) begin
      if (mthi_we) hi_out <= wdata;
      if (mtlo_we) lo_out <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done   <= 1'b0;
      hazard <= 1'b0;
    end else begin
      done   <= (state_q == CAPTURE);
      hazard <= hazard | (busy & (mult_req | mthi_we | mtlo_we));
    end
  end

endmodule

// File: tb/tb_hilo_sequencer.sv
// tb/tb_hilo_sequencer.sv - scoreboard bench for hilo_sequencer with a behavioural multiplier in the loop
module tb_hilo_sequencer;

  localparam int MC = 33;

  logic        clk;
  logic        reset;
  logic        mult_req;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi_we;
  logic        mtlo_we;
  logic [31:0] wdata;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic        mult_start;
  logic [31:0] mult_a;
  logic [31:0] mult_b;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        busy;
  logic        done;
  logic        hazard;

  int nchk = 0;
  int nerr = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;
  logic [31:0] lo_c1;
  int          done_seen;

  hilo_sequencer #(.DATA_W(32), .MULT_CYCLES(MC)) dut (
    .clk        (clk),
    .reset      (reset),
    .mult_req   (mult_req),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .mthi_we    (mthi_we),
    .mtlo_we    (mtlo_we),
    .wdata      (wdata),
    .mult_hi    (mult_hi),
    .mult_lo    (mult_lo),
    .mult_start (mult_start),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .hi_out     (hi_out),
    .lo_out     (lo_out),
    .busy       (busy),
    .done       (done),
    .hazard     (hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: junk until MC edges after the start edge, then the signed product.
  int                 mcnt;
  logic signed [63:0] mprod;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mcnt  <= 0;
      mprod <= '0;
    end else if (mult_start) begin
      mcnt  <= MC;
      mprod <= $signed({{32{mult_a[31]}}, mult_a}) * $signed({{32{mult_b[31]}}, mult_b});
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
    end
  end
  assign mult_hi = (mcnt == 0) ? mprod[63:32] : (32'hBAD0_0000 ^ 32'(mcnt));
  assign mult_lo = (mcnt == 0) ? mprod[31:0]  : (32'h0BAD_0000 ^ 32'(mcnt));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nchk++;
    if (obs !== expv) begin
      nerr++;
      $display("FAIL %s got %h expected %h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("done_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("hi_result", hi_out, mon_e[63:32]);
        check("lo_result", lo_out, mon_e[31:0]);
      end
    end
  end

  // Drives a request in the current cycle (cycle 0) and steps through the done cycle (36).
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input int inj);
    logic signed [63:0] p;
    logic [31:0] hi1, lo1;
    p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    mult_req = 1'b1;
    rs_val   = a;
    rt_val   = b;
    exp_q.push_back(p);
    for (int c = 1; c <= MC + 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        mult_req = 1'b0;
        mthi_we  = 1'b0;
        mtlo_we  = 1'b0;
        hi1      = hi_out;
        lo1      = lo_out;
        lo_c1    = lo_out;
        check("mult_a", mult_a, a);
        check("mult_b", mult_b, b);
      end
      check("mult_start", mult_start, (c == 1));
      check("busy", busy, (c <= MC + 2));
      check("done_cycle", done, (c == MC + 3));
      if (inj != 0 && c == inj + 1) begin
        mult_req = 1'b0;
        mthi_we  = 1'b0;
        check("hazard_set", hazard, 1);
        check("mult_a_hold", mult_a, a);
      end
      if (c == inj) begin
        mult_req = 1'b1;
        rs_val   = ~a;
        rt_val   = ~b;
        mthi_we  = 1'b1;
        wdata    = 32'h1234_5678;
      end
      if (c == MC + 2) begin
        check("hi_hold", hi_out, hi1);
        check("lo_hold", lo_out, lo1);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    mult_req = 1'b0;
    rs_val   = '0;
    rt_val   = '0;
    mthi_we  = 1'b0;
    mtlo_we  = 1'b0;
    wdata    = '0;
    done_seen = 0;
    #1;
    check("rst_outputs", {mult_start, busy, done, hazard}, 4'b0000);
    check("rst_hilo", {hi_out, lo_out}, 64'd0);
    check("rst_ab", {mult_a, mult_b}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 7 * -3
    do_mult(32'd7, 32'hFFFF_FFFD, 0);

    // Simultaneous MTHI/MTLO in IDLE
    mthi_we = 1'b1;
    mtlo_we = 1'b1;
    wdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    mthi_we = 1'b0;
    mtlo_we = 1'b0;
    check("mthi_val", hi_out, 32'hDEAD_BEEF);
    check("mtlo_val", lo_out, 32'hDEAD_BEEF);
    check("mt_no_done", done, 0);
    check("mt_no_hazard", hazard, 0);

    // Request and MTHI while busy at cycle 10
    do_mult(32'hFFFF_FF9C, 32'd12345, 10);

    // MTLO together with a request
    mtlo_we = 1'b1;
    wdata   = 32'd5;
    do_mult(32'd2, 32'd3, 0);
    check("mtlo_with_req", lo_c1, 32'd5);
    check("hazard_sticky", hazard, 1);

    // Reset during WAIT
    mult_req = 1'b1;
    rs_val   = 32'd1000;
    rt_val   = 32'd1000;
    exp_q.push_back(64'd1000000);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      mult_req = 1'b0;
    end
    reset = 1'b1;
    void'(exp_q.pop_back());
    #1;
    check("mid_rst_ctrl", {mult_start, busy, done, hazard}, 4'b0000);
    check("mid_rst_hilo", {hi_out, lo_out}, 64'd0);
    check("mid_rst_ab", {mult_a, mult_b}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) @(negedge clk);
    check("no_done_after_rst", done_seen, 0);
    do_mult(32'hFFFF_FFF9, 32'hFFFF_FFF7, 0);

    // Back-to-back: second request driven in the done cycle
    do_mult(32'd123456, 32'd654321, 0);
    do_mult(32'h8000_0000, 32'd2, 0);
    check("b2b_no_hazard", hazard, 0);

    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/hilo_sequencer.md
# hilo_sequencer

- Sits directly downstream of the sequential Booth multiplier and between it and the control unit.
- Accepts a MULT request with operands and fires the multiplier's one-cycle start pulse.
- Counts the multiplier's fixed iteration latency, then captures its Hi/Lo result into the architectural HI/LO registers.
- Also serves MTHI/MTLO writes and exposes HI/LO for MFHI/MFLO, with busy/done handshaking back to the control unit.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- MULT_CYCLES, 33, clock edges after the edge sampling mult_start high until mult_hi/mult_lo are final and stable

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- mult_req  in  1  control unit requests a multiply; sampled on clk
- rs_val  in  DATA_W  multiplicand, sampled with accepted mult_req
- rt_val  in  DATA_W  multiplier, sampled with accepted mult_req
- mthi_we  in  1  write wdata to HI
- mtlo_we  in  1  write wdata to LO
- wdata  in  DATA_W  MTHI/MTLO data
- mult_hi  in  DATA_W  multiplier upper result
- mult_lo  in  DATA_W  multiplier lower result
- mult_start  out  1  one-cycle start pulse to multiplier control input
- mult_a  out  DATA_W  registered multiplicand to multiplier
- mult_b  out  DATA_W  registered multiplier to multiplier
- hi_out  out  DATA_W  architectural HI
- lo_out  out  DATA_W  architectural LO
- busy  out  1  high in START, WAIT, CAPTURE
- done  out  1  one-cycle pulse, coincident with the first cycle new HI/LO are visible
- hazard  out  1  sticky; set by any mult_req/mthi_we/mtlo_we while busy

## Operation
Reset values: all outputs 0, state IDLE, counter 0.

FSM:
- IDLE: mult_req=1 → latch rs_val/rt_val into mult_a/mult_b, go START.
- START: mult_start=1 for exactly this cycle; load counter with MULT_CYCLES; go WAIT.
- WAIT: decrement counter each edge; at the edge where counter==1, go CAPTURE.
- CAPTURE: at the exit edge, hi_out←mult_hi and lo_out←mult_lo; done register set; go IDLE.

Busy behaviour:
- mult_a/mult_b hold until the next accepted request.
- mult_req, mthi_we and mtlo_we are ignored while busy; each such attempt sets hazard.
- hazard clears only on reset.

IDLE behaviour:
- mthi_we/mtlo_we write wdata at the edge; both may assert together, and both registers take wdata.
- MTHI/MTLO plus mult_req in the same IDLE cycle: the write is performed, the multiply starts, and CAPTURE later overwrites HI/LO.
- hi_out/lo_out are pure registers and hold their old values throughout busy. The control unit must stall MFHI/MFLO until done/!busy.

Reset mid-operation: immediate return to IDLE, mult_start deasserts asynchronously, and no capture happens. The multiplier shares the same reset.

## Timing
- Req sampled at edge E0. START is cycle 1, so the multiplier samples start at E1.
- WAIT occupies cycles 2..MULT_CYCLES+1. CAPTURE is cycle MULT_CYCLES+2.
- done=1 with new HI/LO in cycle MULT_CYCLES+3, which is 36 for the default.
- busy=1 in cycles 1..MULT_CYCLES+2. The earliest next mult_req is accepted at the edge ending the done cycle.
- Counter width: $clog2(MULT_CYCLES+1). The counter never wraps, because it is only decremented while nonzero.

## Structure
- Package hilo_pkg holds:
  - the state typedef: IDLE=2'b00, START=2'b01, WAIT=2'b10, CAPTURE=2'b11;
  - the default MULT_CYCLES constant;
  - the counter-width constant.
- One sub-module is natural: hilo_wait_counter, a loadable down-counter with a terminal-count (==1) flag.

## Test plan
- rs=7, rt=-3, mult_req pulse, multiplier in loop:
  - mult_start high exactly in cycle 1;
  - done in cycle 36;
  - hi_out=32'hFFFFFFFF, lo_out=32'hFFFFFFEB.
- Idle, mthi_we=mtlo_we=1, wdata=32'hDEADBEEF → both registers read DEADBEEF next cycle; done stays 0.
- mult_req at cycle 10 of an active multiply → ignored, hazard=1, mult_a unchanged; the first result still completes at cycle 36.
- mtlo_we + mult_req same IDLE cycle (wdata=5; rs=2, rt=3) → lo_out=5 next cycle, then hi_out=0, lo_out=6 at done.
- Assert reset during WAIT (cycle 20) → state IDLE, all outputs 0 immediately, no done pulse; a fresh request afterwards completes normally.
- Back-to-back: second mult_req held high from the done cycle → accepted at the end of the done cycle; second done 36 cycles later with the correct product.
